// File: rtl/issue_div_fifo.sv
// issue_div_fifo: circular queue between the issue stage and the divider.
// Issue pushes issue_execute_pack_t entries. The divider sees the head entry
// with a valid/pop handshake. A commit flush empties the queue.
// Optional feature macro: ISSUE_DIV_FIFO_BYPASS_EN. When it is defined, an
// entry pushed into an empty queue is visible in the same cycle.

package issue_div_fifo_pkg;

  typedef enum logic [3:0] {
    EXC_NONE                  = 4'd0,
    EXC_INSTRUCTION_MISALIGN  = 4'd1,
    EXC_ILLEGAL_INSTRUCTION   = 4'd2,
    EXC_BREAKPOINT            = 4'd3
  } exception_id_t;

  typedef struct packed {
    logic          enable;
    logic          valid;
    logic [6:0]    rob_id;
    logic [31:0]   inst;
    logic [2:0]    sub_op;
    logic [5:0]    rs1_phy;
    logic [31:0]   src1_value;
    logic [5:0]    rs2_phy;
    logic [31:0]   src2_value;
    logic          rd_enable;
    logic [5:0]    rd_phy;
    logic          has_exception;
    exception_id_t exception_id;
    logic [31:0]   exception_value;
  } issue_execute_pack_t;

endpackage

module issue_div_fifo
  import issue_div_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  issue_execute_pack_t       issue_div_fifo_data_in,
  input  logic                      issue_div_fifo_push,
  output logic                      issue_div_fifo_full,
  input  logic                      issue_div_fifo_flush,
  output issue_execute_pack_t       issue_div_fifo_data_out,
  output logic                      issue_div_fifo_data_out_valid,
  input  logic                      issue_div_fifo_pop,
  output logic [$clog2(DEPTH):0]    issue_div_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  issue_execute_pack_t mem_q [DEPTH];

  logic [PW-1:0] readPtr_q;
  logic [PW-1:0] readPtr_d;
  logic [PW-1:0] writePtr_q;
  logic [PW-1:0] writePtr_d;

  logic empty;
  logic fullFlag;
  logic bypassTake;
  logic pushAcc;
  logic popAcc;

  // The pointers carry one extra wrap bit. Equal pointers mean the queue is
  // empty. Equal index bits with different wrap bits mean the queue is full.
  assign empty    = (readPtr_q == writePtr_q);
  assign fullFlag = (readPtr_q[AW-1:0] == writePtr_q[AW-1:0]) &&
                    (readPtr_q[AW] != writePtr_q[AW]);

`ifdef ISSUE_DIV_FIFO_BYPASS_EN
  // On an empty queue, a push with a pop in the same cycle goes straight to
  // the divider. Storage is not written.
  assign bypassTake = empty && issue_div_fifo_push && !issue_div_fifo_flush &&
                      issue_div_fifo_pop;
`else
  assign bypassTake = 1'b0;
`endif

  // The full flag comes from the current state. A pop in the same cycle
  // therefore does not make room for a push.
  assign pushAcc = issue_div_fifo_push && !fullFlag && !issue_div_fifo_flush &&
                   !bypassTake;
  assign popAcc  = issue_div_fifo_pop && !empty && !issue_div_fifo_flush;

  // Next-state pointers. Flush takes priority and drops all entries.
  always_comb begin
    readPtr_d  = readPtr_q;
    writePtr_d = writePtr_q;
    if (issue_div_fifo_flush) begin
      readPtr_d  = '0;
      writePtr_d = '0;
    end else begin
      if (pushAcc) begin
        writePtr_d = writePtr_q + PW'(1);
      end
      if (popAcc) begin
        readPtr_d = readPtr_q + PW'(1);
      end
    end
  end

  // Pointer registers. Reset clears them asynchronously, so the queue is empty at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readPtr_q  <= '0;
      writePtr_q <= '0;
    end else begin
      readPtr_q  <= readPtr_d;
      writePtr_q <= writePtr_d;
    end
  end

  // Entry storage. It needs no reset because the pointers mark which entries are live.
  always_ff @(posedge clk) begin
    if (pushAcc) begin
      mem_q[writePtr_q[AW-1:0]] <= issue_div_fifo_data_in;
    end
  end

  // Head presentation. The output is all-zero when empty, so enable reads 0.
  always_comb begin
    issue_div_fifo_data_out       = '0;
    issue_div_fifo_data_out_valid = 1'b0;
    if (!empty) begin
      issue_div_fifo_data_out       = mem_q[readPtr_q[AW-1:0]];
      issue_div_fifo_data_out_valid = 1'b1;
    end
`ifdef ISSUE_DIV_FIFO_BYPASS_EN
    else if (issue_div_fifo_push && !issue_div_fifo_flush) begin
      issue_div_fifo_data_out       = issue_div_fifo_data_in;
      issue_div_fifo_data_out_valid = 1'b1;
    end
`endif
  end

  assign issue_div_fifo_full  = fullFlag;
  assign issue_div_fifo_count = writePtr_q - readPtr_q;

endmodule

// File: tb/tb_issue_div_fifo.sv
// Self-checking bench for issue_div_fifo with DEPTH = 4.
// A scoreboard queue holds the entries expected at the head. Each accepted
// push adds to the queue. Each accepted pop removes the front entry and
// compares it with data_out.

module tb_issue_div_fifo;
  import issue_div_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clk;
  logic                rst;
  issue_execute_pack_t dataIn;
  logic                pushIn;
  logic                fullOut;
  logic                flushIn;
  issue_execute_pack_t dataOut;
  logic                validOut;
  logic                popIn;
  logic [CW-1:0]       countOut;

  int tests;
  int fails;
  issue_execute_pack_t expQ[$];

  issue_div_fifo #(.DEPTH(DEPTH)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .issue_div_fifo_data_in        (dataIn),
    .issue_div_fifo_push           (pushIn),
    .issue_div_fifo_full           (fullOut),
    .issue_div_fifo_flush          (flushIn),
    .issue_div_fifo_data_out       (dataOut),
    .issue_div_fifo_data_out_valid (validOut),
    .issue_div_fifo_pop            (popIn),
    .issue_div_fifo_count          (countOut)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_execute_pack_t mkEntry(input int rob);
    issue_execute_pack_t e;
    e            = '0;
    e.enable     = 1'b1;
    e.valid      = 1'b1;
    e.rob_id     = 7'(rob);
    e.inst       = 32'h0200_4033 ^ 32'(rob);
    e.sub_op     = 3'(rob % 8);
    e.rs1_phy    = 6'(rob + 2);
    e.src1_value = 32'(rob * 3 + 1);
    e.rs2_phy    = 6'(rob + 5);
    e.src2_value = 32'(rob + 100);
    e.rd_enable  = 1'b1;
    e.rd_phy     = 6'(rob + 1);
    return e;
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input logic [CW-1:0] obs, input int exp);
    tests++;
    assert (obs === CW'(exp)) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkEntry(input string tag, input issue_execute_pack_t obs,
                            input issue_execute_pack_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed rob %0d (%0h) expected rob %0d (%0h)",
             tag, obs.rob_id, obs, exp.rob_id, exp);
    end
  endtask

  // Drive one cycle. Check the head before the edge, then check the state
  // flags after the edge.
  task automatic driveCycle(input logic push, input logic pop, input logic flush,
                            input issue_execute_pack_t din);
    bit pushOk;
    bit popOk;
    bit bypassHit;
    issue_execute_pack_t front;
    pushIn  = push;
    popIn   = pop;
    flushIn = flush;
    dataIn  = din;
    #3;
    bypassHit = 1'b0;
`ifdef ISSUE_DIV_FIFO_BYPASS_EN
    bypassHit = push && !flush && (expQ.size() == 0);
`endif
    pushOk = push && !flush && (expQ.size() < DEPTH);
    popOk  = pop && !flush && (expQ.size() > 0);
    if (bypassHit) begin
      checkBit("bypassValid", validOut, 1'b1);
      checkEntry("bypassData", dataOut, din);
      if (pop) pushOk = 1'b0;
    end else if (popOk) begin
      front = expQ.pop_front();
      checkBit("headValid", validOut, 1'b1);
      checkEntry("headData", dataOut, front);
    end
    if (flush) expQ.delete();
    if (pushOk) expQ.push_back(din);
    @(posedge clk);
    #1;
    pushIn  = 1'b0;
    popIn   = 1'b0;
    flushIn = 1'b0;
    dataIn  = '0;
    #1;
    checkCount("count", countOut, expQ.size());
    checkBit("valid", validOut, expQ.size() > 0);
    checkBit("full", fullOut, expQ.size() == DEPTH);
  endtask

  initial begin
    issue_execute_pack_t e;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    pushIn  = 1'b0;
    popIn   = 1'b0;
    flushIn = 1'b0;
    dataIn  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset and idle values
    checkBit("rstValid", validOut, 1'b0);
    checkBit("rstFull", fullOut, 1'b0);
    checkCount("rstCount", countOut, 0);
    checkBit("rstEnable", dataOut.enable, 1'b0);
    checkEntry("rstData", dataOut, '0);

    // An asynchronous reset mid-cycle with two entries queued
    driveCycle(1'b1, 1'b0, 1'b0, mkEntry(40));
    driveCycle(1'b1, 1'b0, 1'b0, mkEntry(41));
    #2;
    rst = 1'b1;
    #1;
    checkCount("asyncRstCount", countOut, 0);
    checkBit("asyncRstValid", validOut, 1'b0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Fill to full, drop a fifth push, then drain in order
    for (int k = 1; k <= 4; k++) begin
      driveCycle(1'b1, 1'b0, 1'b0, mkEntry(k));
    end
    driveCycle(1'b1, 1'b0, 1'b0, mkEntry(5));
    for (int k = 0; k < 4; k++) begin
      driveCycle(1'b0, 1'b1, 1'b0, '0);
    end
    driveCycle(1'b0, 1'b1, 1'b0, '0);

    // Push and pop every cycle so the pointers wrap
    for (int k = 0; k < 10; k++) begin
      driveCycle(1'b1, 1'b1, 1'b0, mkEntry(k));
    end
    driveCycle(1'b0, 1'b1, 1'b0, '0);

    // Flush with three entries queued and push/pop asserted in the same cycle
    driveCycle(1'b1, 1'b0, 1'b0, mkEntry(20));
    driveCycle(1'b1, 1'b0, 1'b0, mkEntry(21));
    driveCycle(1'b1, 1'b0, 1'b0, mkEntry(22));
    driveCycle(1'b1, 1'b1, 1'b1, mkEntry(30));
    driveCycle(1'b1, 1'b0, 1'b0, mkEntry(7));
    checkVal("postFlushHead", 32'(dataOut.rob_id), 32'd7);
    driveCycle(1'b0, 1'b1, 1'b0, '0);

    // Exception and operand fields pass through unmodified
    e               = mkEntry(50);
    e.has_exception = 1'b1;
    e.exception_id  = EXC_ILLEGAL_INSTRUCTION;
    e.exception_value = 32'hDEAD_0013;
    driveCycle(1'b1, 1'b0, 1'b0, e);
    e            = mkEntry(51);
    e.src1_value = 32'd12;
    e.src2_value = 32'd6;
    driveCycle(1'b1, 1'b0, 1'b0, e);
    driveCycle(1'b0, 1'b1, 1'b0, '0);
    driveCycle(1'b0, 1'b1, 1'b0, '0);

    // Push and pop together on an empty queue
    e       = mkEntry(3);
    dataIn  = e;
    pushIn  = 1'b1;
    popIn   = 1'b1;
    #3;
`ifdef ISSUE_DIV_FIFO_BYPASS_EN
    checkBit("bypassSameCycleValid", validOut, 1'b1);
    checkVal("bypassSameCycleRob", 32'(dataOut.rob_id), 32'd3);
`else
    checkBit("noBypassSameCycleValid", validOut, 1'b0);
`endif
    @(posedge clk);
    #1;
    pushIn = 1'b0;
    popIn  = 1'b0;
    dataIn = '0;
    #1;
`ifdef ISSUE_DIV_FIFO_BYPASS_EN
    checkCount("bypassCountAfter", countOut, 0);
`else
    checkCount("noBypassCountAfter", countOut, 1);
    expQ.push_back(e);
    driveCycle(1'b0, 1'b1, 1'b0, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_div_fifo.md
# issue_div_fifo

Single-clock circular queue between the issue stage and the divider execute unit. It buffers `issue_execute_pack_t` entries pushed by issue and presents the head entry to the divider with a valid/pop handshake. A commit-driven flush empties it. It is the producer end of the interface that `execute_div` reads.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; a power of two, at least 2.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `issue_div_fifo_data_in`, in, `issue_execute_pack_t`: entry from issue.
- `issue_div_fifo_push`, in, 1: issue requests a write of `data_in` this cycle.
- `issue_div_fifo_full`, out, 1: no free entry; issue must not push.
- `issue_div_fifo_flush`, in, 1: discard all entries; driven from `commit_feedback_pack.enable && commit_feedback_pack.flush`.
- `issue_div_fifo_data_out`, out, `issue_execute_pack_t`: head entry.
- `issue_div_fifo_data_out_valid`, out, 1: the head entry is present.
- `issue_div_fifo_pop`, in, 1: the divider consumes the head this cycle.
- `issue_div_fifo_count`, out, `$clog2(DEPTH)+1`: current occupancy, 0..DEPTH.

## Operation
- Storage is `DEPTH` entries plus read and write pointers of `$clog2(DEPTH)+1` bits. The extra MSB is the wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - count = wptr − rptr, modulo 2^(log2 DEPTH + 1).
- Push is accepted when `push && !full && !flush`. The entry is written at `wptr` and `wptr` increments. A push while full is dropped silently and the pointers stay unchanged. A push while full is dropped even if a pop happens in the same cycle; the full flag is evaluated from current state.
- Pop is accepted when `pop && data_out_valid && !flush`, and `rptr` increments. A pop while invalid is ignored.
- A simultaneous accepted push and pop leaves count unchanged. Both pointers advance, including across the wrap from index DEPTH−1 to index 0.
- Flush sets both pointers to 0 at the next edge. A push or pop in the flush cycle is ignored, and no entry survives the flush.
- `data_out` is the entry at `rptr` when non-empty. When empty it is all-zero, so `data_out.enable` = 0.
- The block does no payload interpretation. Exception fields, `valid` and `enable` pass through unmodified.
- Reset value of every output:
  - `full` = 0
  - `data_out_valid` = 0
  - `data_out` = 0
  - `count` = 0
  - All pointers are 0. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, asynchronously, without waiting for a clock edge.

## Timing
- Push-to-visible latency is 1 cycle. A push accepted at edge N gives `data_out_valid` = 1 after edge N.
- Pop: the head is consumed at the edge where `pop` is high. The next entry, or invalid, is visible after that edge.
- Throughput is one push and one pop per cycle.
- All outputs are registered-state functions (pointers and storage). There is no combinational path from `push` or `pop` to any output. The one exception is under the bypass macro, described under Configuration.
- Flush at edge N gives `valid` = 0, `count` = 0 and `full` = 0 after edge N.

## Configuration
- `ISSUE_DIV_FIFO_BYPASS_EN` defined:
  - When the FIFO is empty and `push && !flush`, `data_out` = `data_in` and `data_out_valid` = 1 combinationally in the same cycle.
  - If `pop` is also high that cycle, the entry is consumed directly. Storage is not written and no pointer moves.
  - If `pop` is low, the entry is written normally.
  - The resulting latency is 0 cycles.
- Macro undefined: no bypass, the 1-cycle latency applies, and no input reaches an output combinationally.

## Test plan
- Reset, then idle: `valid` = 0, `full` = 0, `count` = 0, `data_out.enable` = 0. Assert `rst` asynchronously mid-cycle with 2 entries queued: `count` reads 0 before the next edge.
- DEPTH = 4, push `rob_id` 1..4 on consecutive cycles with no pop:
  - `count` reads 1, 2, 3, 4.
  - `full` = 1 after the 4th push.
  - A 5th push with `rob_id` 5 is dropped and `count` stays 4.
  - Popping 4 times then yields `rob_id` 1, 2, 3, 4 in order, followed by `valid` = 0.
- Wrap-around: push and pop every cycle for 10 cycles with `rob_id` 0..9. Each `rob_id` k appears on `data_out` exactly one cycle after it was pushed, and `count` holds at 1.
- Flush with 3 entries queued while `push` = 1 and `pop` = 1 in the same cycle: after the edge `count` = 0, `valid` = 0 and `full` = 0. The next push of `rob_id` 7 is the head one cycle later.
- Pass-through of payload: push an entry with `has_exception` = 1 and `exception_id` = illegal_instruction, then another with `src1_value` = 12 and `src2_value` = 6. Both appear unmodified on `data_out`, in order.
- With `ISSUE_DIV_FIFO_BYPASS_EN` defined, on an empty FIFO push `rob_id` 3 with `pop` = 1 in the same cycle: `data_out.rob_id` = 3 and `valid` = 1 in that cycle, and `count` stays 0 after the edge. Without the macro, the same stimulus gives `valid` = 0 in that cycle and `count` = 1 after the edge.
